brick_field: RTL and testbench
==============================

Name: brick_field

Overview:
- Parametrised ROWS x COLS brick grid manager for the brick-breaker game. It replaces the fixed set of per-brick instances with one block.
- Owns the brick exist bitmap and a per-brick hit-point counter.
- Once per frame, scans the grid sequentially (one brick per clock) against the ball bounding box. Reports at most one hit per frame with bounce-axis flags, and keeps score and brick count.
- Sits between the ball and collision logic and the VGA renderer inside game_logic.

Parameters:
- ROWS, 2, brick rows
- COLS, 6, bricks per row
- COORD_W, 10, coordinate width in bits
- ORIGIN_X, 134, x of brick 0 left edge
- ORIGIN_Y, 18, y of brick 0 top edge
- BRICK_W, 60, brick width in px
- BRICK_H, 12, brick height in px
- GAP_X, 3, horizontal gap between bricks
- GAP_Y, 3, vertical gap between bricks
- BALL_SIZE, 8, ball square side in px
- HP_W, 2, hit-point counter width
- INIT_HP, 1, hit points loaded per brick, must be >= 1
- POINTS, 10, score added per destroyed brick
- SCORE_W, 16, score width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- frame_tick  input  1  one-cycle pulse that starts a scan
- reload  input  1  one-cycle pulse that re-initialises the field
- ball_x  input  COORD_W  ball top-left x, sampled at frame_tick
- ball_y  input  COORD_W  ball top-left y, sampled at frame_tick
- exist  output  ROWS*COLS  bit i = brick i present; i = row*COLS+col
- hit_valid  output  1  one-cycle hit pulse
- hit_index  output  $clog2(ROWS*COLS)  index of the hit brick
- flip_x  output  1  ball must reverse dx; valid with hit_valid
- flip_y  output  1  ball must reverse dy; valid with hit_valid
- scan_done  output  1  one-cycle pulse at the end of every scan
- busy  output  1  high while a scan is in progress
- score  output  SCORE_W  accumulated score
- bricks_left  output  $clog2(ROWS*COLS+1)  bricks present
- level_clear  output  1  sticky flag: all bricks destroyed

Behaviour:
- Reset (rst low, async) sets:
  - exist to all ones; every HP to INIT_HP; bricks_left to ROWS*COLS.
  - score 0; level_clear 0; all pulses 0; FSM to IDLE.
- FSM states:
  - IDLE: on frame_tick with level_clear=0 and reload=0, latch ball_x and ball_y, clear the row and column counters, go to SCAN.
  - SCAN: evaluate brick (row, col) each cycle. Advance col, then row. Brick x and y come from running accumulators stepped by BRICK_W+GAP_X and BRICK_H+GAP_Y; no multipliers.
    - On the first overlapping present brick, go to HIT.
    - After the last index with no hit, pulse scan_done and go to IDLE.
  - HIT (one cycle):
    - Decrement that brick's HP.
    - If HP reaches 0: clear its exist bit, decrement bricks_left, add POINTS to score.
    - Pulse hit_valid, hit_index, flip_x, flip_y and scan_done, then go to IDLE.
- Latency:
  - Brick i is evaluated i+1 cycles after the frame_tick cycle.
  - hit_valid fires one cycle after the hit brick's evaluation cycle.
  - A miss scan takes ROWS*COLS cycles from frame_tick to scan_done.
- Overlap test, strict and half-open: ball [bx, bx+BALL_SIZE) against brick [x, x+BRICK_W) on the x axis, and the same on the y axis.
  - Sums are computed at COORD_W+1 bits, so there is no wrap near the screen edge.
  - Bricks with exist=0 never hit.
- Bounce axis:
  - Ball centre x = bx + BALL_SIZE/2.
  - If centre x lies in [x, x+BRICK_W): flip_y=1, flip_x=0.
  - Otherwise: flip_x=1, flip_y=0.
- Hit limits: one hit per frame maximum, and the lowest index wins.
- Ignored inputs: frame_tick during SCAN or HIT is ignored (no queueing). frame_tick while level_clear=1 is ignored (no scan, no scan_done).
- Score saturates at all ones; it never wraps.
- level_clear:
  - Sets in the cycle after bricks_left becomes 0.
  - Stays set until reload or reset.
- reload, in any state:
  - Aborts any scan; the FSM goes to IDLE with no pulses.
  - Restores exist, HP and bricks_left to their reset values and clears level_clear.
  - Does not change score.
  - reload wins over a simultaneous frame_tick.
- Reset mid-scan: immediate return to the reset state; no pulses emitted.

Decomposition:
- Package brick_pkg holds the FSM state enum (IDLE, SCAN, HIT) and geometry helper constants: pitch X = BRICK_W+GAP_X, pitch Y = BRICK_H+GAP_Y, N = ROWS*COLS.
- One natural sub-module, brick_hp_bank: an N-entry HP and exist register array with load-all and decrement-one ports. It outputs the exist vector and a zero flag for the addressed entry.

Test Plan:
- Reset: exist=12'hFFF, bricks_left=12, score=0, level_clear=0, busy=0.
- Miss: ball (10,300), tick → no hit_valid; scan_done exactly 12 cycles after the tick.
- Top hit: ball (150,26), tick → hit_valid 2 cycles after tick, hit_index=0, flip_y=1, exist[0]=0, score=10, bricks_left=11.
- Side hit: ball (128,20) → hit_index=0, flip_x=1, flip_y=0.
- Straddle: ball (190,22) overlaps bricks 0 and 1 → only index 0 reported; a second tick then reports index 1.
- Multi-hit: INIT_HP=2, ball (150,26) over two ticks → first tick hit_valid with exist[0] still 1 and score 0; second tick clears the brick and score becomes 10.
- Clear and abort:
  - Destroy all 12 bricks → level_clear=1 and the next tick is ignored.
  - reload → exist all ones, bricks_left=12, score kept at 120.
  - rst low during SCAN → no pulses, state reset.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared types and geometry helpers for the brick field manager.
package brick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2
  } state_e;

  function automatic int pitch(input int size, input int gap);
    return size + gap;
  endfunction

  function automatic int grid_n(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/brick_hp_bank.sv
// Per-brick hit-point counters and exist bits with load-all and decrement-one ports.
module brick_hp_bank #(
  parameter int N       = 12,
  parameter int HP_W    = 2,
  parameter int INIT_HP = 1,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [IDX_W-1:0] addr_i,
  output logic [N-1:0]     exist_o,
  output logic             zero_o
);

  logic [HP_W-1:0] hp_q [N];
  logic [N-1:0]    exist_q;

  // zero_o means the addressed entry reaches zero if decremented now
  assign zero_o  = (hp_q[addr_i] == HP_W'(1));
  assign exist_o = exist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exist_q <= {N{1'b1}};
      for (int i = 0; i < N; i++) hp_q[i] <= HP_W'(INIT_HP);
    end else if (load_i) begin
      exist_q <= {N{1'b1}};
      for (int i = 0; i < N; i++) hp_q[i] <= HP_W'(INIT_HP);
    end else if (dec_i) begin
      hp_q[addr_i] <= hp_q[addr_i] - HP_W'(1);
      if (zero_o) exist_q[addr_i] <= 1'b0;
    end
  end

endmodule

// File: rtl/brick_field.sv
// Brick grid manager: one-brick-per-clock scan against the ball box, hit
// reporting with bounce axis, score and brick count bookkeeping.
module brick_field
  import brick_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int COLS      = 6,
  parameter int COORD_W   = 10,
  parameter int ORIGIN_X  = 134,
  parameter int ORIGIN_Y  = 18,
  parameter int BRICK_W   = 60,
  parameter int BRICK_H   = 12,
  parameter int GAP_X     = 3,
  parameter int GAP_Y     = 3,
  parameter int BALL_SIZE = 8,
  parameter int HP_W      = 2,
  parameter int INIT_HP   = 1,
  parameter int POINTS    = 10,
  parameter int SCORE_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_tick,
  input  logic                             reload,
  input  logic [COORD_W-1:0]               ball_x,
  input  logic [COORD_W-1:0]               ball_y,
  output logic [ROWS*COLS-1:0]             exist,
  output logic                             hit_valid,
  output logic [$clog2(ROWS*COLS)-1:0]     hit_index,
  output logic                             flip_x,
  output logic                             flip_y,
  output logic                             scan_done,
  output logic                             busy,
  output logic [SCORE_W-1:0]               score,
  output logic [$clog2(ROWS*COLS+1)-1:0]   bricks_left,
  output logic                             level_clear
);

  localparam int N     = grid_n(ROWS, COLS);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);
  localparam int PX    = pitch(BRICK_W, GAP_X);
  localparam int PY    = pitch(BRICK_H, GAP_Y);
  localparam int CW    = COORD_W + 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;

  state_e             state_q;
  logic [COORD_W-1:0] bx_q, by_q;
  logic [RW-1:0]      row_q;
  logic [CLW-1:0]     col_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CW-1:0]      xacc_q, yacc_q;
  logic               hit_valid_q, flip_x_q, flip_y_q, level_clear_q;
  logic [IDX_W-1:0]   hit_index_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   left_q;

  logic [CW-1:0]      ball_l_s, ball_r_s, ball_t_s, ball_b_s, ctr_s, brick_r_s, brick_b_s;
  logic               ov_x_s, ov_y_s, ctr_in_s, overlap_s, last_s, miss_done_s, dec_s, zero_s;
  logic [SCORE_W:0]   score_sum_s;

  // Overlap and bounce-axis test for the brick under evaluation, one bit wider than coordinates
  always_comb begin
    ball_l_s    = {1'b0, bx_q};
    ball_t_s    = {1'b0, by_q};
    ball_r_s    = ball_l_s + CW'(BALL_SIZE);
    ball_b_s    = ball_t_s + CW'(BALL_SIZE);
    ctr_s       = ball_l_s + CW'(BALL_SIZE / 2);
    brick_r_s   = xacc_q + CW'(BRICK_W);
    brick_b_s   = yacc_q + CW'(BRICK_H);
    ov_x_s      = (ball_l_s < brick_r_s) && (xacc_q < ball_r_s);
    ov_y_s      = (ball_t_s < brick_b_s) && (yacc_q < ball_b_s);
    ctr_in_s    = (xacc_q <= ctr_s) && (ctr_s < brick_r_s);
    overlap_s   = (state_q == SCAN) && exist[idx_q] && ov_x_s && ov_y_s;
    last_s      = (row_q == RW'(ROWS - 1)) && (col_q == CLW'(COLS - 1));
    miss_done_s = (state_q == SCAN) && last_s && !overlap_s && !reload;
    dec_s       = (state_q == HIT) && !reload;
    score_sum_s = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
    score_d     = score_sum_s[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
  end

  // Scan FSM with registered hit report, score and brick count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bx_q          <= '0;
      by_q          <= '0;
      row_q         <= '0;
      col_q         <= '0;
      idx_q         <= '0;
      xacc_q        <= CW'(ORIGIN_X);
      yacc_q        <= CW'(ORIGIN_Y);
      hit_valid_q   <= 1'b0;
      hit_index_q   <= '0;
      flip_x_q      <= 1'b0;
      flip_y_q      <= 1'b0;
      score_q       <= '0;
      left_q        <= CNT_W'(N);
      level_clear_q <= 1'b0;
    end else begin
      hit_valid_q <= 1'b0;
      if (reload) begin
        state_q       <= IDLE;
        left_q        <= CNT_W'(N);
        level_clear_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (frame_tick && !level_clear_q) begin
              bx_q    <= ball_x;
              by_q    <= ball_y;
              row_q   <= '0;
              col_q   <= '0;
              idx_q   <= '0;
              xacc_q  <= CW'(ORIGIN_X);
              yacc_q  <= CW'(ORIGIN_Y);
              state_q <= SCAN;
            end
          end
          SCAN: begin
            if (overlap_s) begin
              hit_valid_q <= 1'b1;
              hit_index_q <= idx_q;
              flip_x_q    <= !ctr_in_s;
              flip_y_q    <= ctr_in_s;
              state_q     <= HIT;
            end else if (last_s) begin
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              if (col_q == CLW'(COLS - 1)) begin
                col_q  <= '0;
                row_q  <= row_q + RW'(1);
                xacc_q <= CW'(ORIGIN_X);
                yacc_q <= yacc_q + CW'(PY);
              end else begin
                col_q  <= col_q + CLW'(1);
                xacc_q <= xacc_q + CW'(PX);
              end
            end
          end
          HIT: begin
            if (zero_s) begin
              left_q  <= left_q - CNT_W'(1);
              score_q <= score_d;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
        if (left_q == '0) level_clear_q <= 1'b1;
      end
    end
  end

  brick_hp_bank #(
    .N      (N),
    .HP_W   (HP_W),
    .INIT_HP(INIT_HP),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .load_i (reload),
    .dec_i  (dec_s),
    .addr_i (hit_index_q),
    .exist_o(exist),
    .zero_o (zero_s)
  );

  assign hit_valid   = hit_valid_q;
  assign hit_index   = hit_index_q;
  assign flip_x      = flip_x_q;
  assign flip_y      = flip_y_q;
  assign scan_done   = hit_valid_q | miss_done_s;
  assign busy        = (state_q != IDLE);
  assign score       = score_q;
  assign bricks_left = left_q;
  assign level_clear = level_clear_q;

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: expected hits are queued by the stimulus
// and consumed by per-instance monitors whenever hit_valid is seen.
module tb_brick_field;

  logic        clk = 1'b0;
  logic        rst, rl, ft0, ft1;
  logic [9:0]  bx, by;
  logic [11:0] ex0, ex1;
  logic [3:0]  hi0, hi1, bl0, bl1;
  logic [15:0] sc0, sc1;
  logic        hv0, hv1, fx0, fx1, fy0, fy1, sd0, sd1, bz0, bz1, lc0, lc1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] idx;
    logic       fx;
    logic       fy;
  } hit_t;

  hit_t q0[$];
  hit_t q1[$];
  hit_t e0, e1;

  always #5 clk = ~clk;

  brick_field dut0 (
    .clk(clk), .rst(rst), .frame_tick(ft0), .reload(rl), .ball_x(bx), .ball_y(by),
    .exist(ex0), .hit_valid(hv0), .hit_index(hi0), .flip_x(fx0), .flip_y(fy0),
    .scan_done(sd0), .busy(bz0), .score(sc0), .bricks_left(bl0), .level_clear(lc0)
  );

  brick_field #(.INIT_HP(2)) dut1 (
    .clk(clk), .rst(rst), .frame_tick(ft1), .reload(1'b0), .ball_x(bx), .ball_y(by),
    .exist(ex1), .hit_valid(hv1), .hit_index(hi1), .flip_x(fx1), .flip_y(fy1),
    .scan_done(sd1), .busy(bz1), .score(sc1), .bricks_left(bl1), .level_clear(lc1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Hit monitors: every hit_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (hv0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL hit0_unexpected actual idx=%0d expected none", hi0);
      end else begin
        e0 = q0.pop_front();
        if ({hi0, fx0, fy0} != e0) begin
          errors++;
          $display("FAIL hit0 actual idx=%0d fx=%0d fy=%0d expected idx=%0d fx=%0d fy=%0d",
                   hi0, fx0, fy0, e0.idx, e0.fx, e0.fy);
        end
      end
    end
    if (hv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL hit1_unexpected actual idx=%0d expected none", hi1);
      end else begin
        e1 = q1.pop_front();
        if ({hi1, fx1, fy1} != e1) begin
          errors++;
          $display("FAIL hit1 actual idx=%0d fx=%0d fy=%0d expected idx=%0d fx=%0d fy=%0d",
                   hi1, fx1, fy1, e1.idx, e1.fx, e1.fy);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick(input int d, input int x, input int y);
    @(posedge clk); #1;
    bx = 10'(x);
    by = 10'(y);
    if (d == 0) ft0 = 1'b1; else ft1 = 1'b1;
    @(posedge clk); #1;
    ft0 = 1'b0;
    ft1 = 1'b0;
  endtask

  // One frame: queue the expected hit, tick, measure cycles to scan_done
  task automatic scan(input int d, input int x, input int y, input bit exp_hit,
                      input int idx, input bit efx, input bit efy, input int exp_k);
    int  k;
    logic hv_at;
    k = 0;
    hv_at = 1'b0;
    if (exp_hit) begin
      if (d == 0) q0.push_back({4'(idx), efx, efy});
      else        q1.push_back({4'(idx), efx, efy});
    end
    tick(d, x, y);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((d == 0) ? sd0 : sd1) begin
        k = i;
        hv_at = (d == 0) ? hv0 : hv1;
        break;
      end
    end
    check("scan_done_latency", k, exp_k);
    check("hit_with_done", int'(hv_at), int'(exp_hit));
    @(negedge clk);
  endtask

  initial begin
    int seen;
    rst = 1'b0; rl = 1'b0; ft0 = 1'b0; ft1 = 1'b0; bx = 10'd0; by = 10'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    check("reset_exist", int'(ex0), 12'hFFF);
    check("reset_left", int'(bl0), 12);
    check("reset_score", int'(sc0), 0);
    check("reset_clear", int'(lc0), 0);
    check("reset_busy", int'(bz0), 0);

    scan(0, 10, 300, 1'b0, 0, 1'b0, 1'b0, 12);
    check("miss_exist", int'(ex0), 12'hFFF);

    scan(0, 150, 26, 1'b1, 0, 1'b0, 1'b1, 2);
    check("top_exist", int'(ex0), 12'hFFE);
    check("top_score", int'(sc0), 10);
    check("top_left", int'(bl0), 11);

    do_reset();
    scan(0, 128, 20, 1'b1, 0, 1'b1, 1'b0, 2);

    do_reset();
    scan(0, 190, 22, 1'b1, 0, 1'b1, 1'b0, 2);
    scan(0, 190, 22, 1'b1, 1, 1'b1, 1'b0, 3);
    check("straddle_exist", int'(ex0), 12'hFFC);

    do_reset();
    for (int i = 0; i < 12; i++)
      scan(0, 134 + 63 * (i % 6) + 10, 18 + 15 * (i / 6) + 4, 1'b1, i, 1'b0, 1'b1, i + 2);
    check("clear_left", int'(bl0), 0);
    check("clear_exist", int'(ex0), 0);
    @(negedge clk);
    check("clear_flag", int'(lc0), 1);
    check("clear_score", int'(sc0), 120);

    tick(0, 150, 26);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bz0 || sd0 || hv0) seen = 1;
    end
    check("ignored_tick", seen, 0);

    @(posedge clk); #1 rl = 1'b1;
    @(posedge clk); #1 rl = 1'b0;
    @(negedge clk);
    check("reload_exist", int'(ex0), 12'hFFF);
    check("reload_left", int'(bl0), 12);
    check("reload_score", int'(sc0), 120);
    check("reload_clear", int'(lc0), 0);

    tick(0, 10, 300);
    repeat (4) @(negedge clk);
    check("midscan_busy", int'(bz0), 1);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bz0 || sd0 || hv0) seen = 1;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midscan_no_pulse", seen, 0);
    check("midscan_score", int'(sc0), 0);

    scan(1, 150, 26, 1'b1, 0, 1'b0, 1'b1, 2);
    check("hp2_first_exist0", int'(ex1[0]), 1);
    check("hp2_first_score", int'(sc1), 0);
    check("hp2_first_left", int'(bl1), 12);
    scan(1, 150, 26, 1'b1, 0, 1'b0, 1'b1, 2);
    check("hp2_second_exist0", int'(ex1[0]), 0);
    check("hp2_second_score", int'(sc1), 10);
    check("hp2_second_left", int'(bl1), 11);

    repeat (3) @(negedge clk);
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
